// File: rtl/uart_rx_cfg_if.sv
// Receive-side handshake bundle for uart_rx_cfg: held word, status flags and
// the consumer's ready. master = receiver, slave = consumer.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 rx_break;
  logic                 overrun;

  modport master (
    output rx_valid, rx_data, parity_err, frame_err, rx_break, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_valid, rx_data, parity_err, frame_err, rx_break, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..DATA_BITS data bits, none/even/odd
// parity, 1 or 2 stop bits, parity/framing/break/overrun status, one-entry
// holding register on a valid/ready handshake.
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_rx_cfg #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             i_Clock,
  input  logic             rst_i,
  input  logic             i_Rx_Serial,
  input  logic [CNT_W-1:0] CLKS_PER_BIT,
  input  logic [3:0]       i_Num_Bits,
  input  logic [1:0]       i_Parity_Mode,
  input  logic             i_Two_Stop,
  uart_rx_cfg_if.master    rx_if
);

  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t               state_q, state_nx;
  logic [CNT_W-1:0]     cnt_q, cnt_nx;
  logic [IDX_W-1:0]     idx_q, idx_nx;
  logic [DATA_BITS-1:0] shreg_q, shreg_nx;
  logic [CNT_W-1:0]     cpb_q, cpb_nx;
  logic [IDX_W-1:0]     nbits_q, nbits_nx;
  logic                 par_en_q, par_en_nx;
  logic                 par_odd_q, par_odd_nx;
  logic                 two_q, two_nx;
  logic                 par_bit_q, par_bit_nx;
  logic                 ferr_q, ferr_nx;
  logic                 stop_low_q, stop_low_nx;
  logic                 stop2_q, stop2_nx;
  logic                 done_q, done_nx;

  logic                 sync_1, rx_s;
  logic                 line;
  logic                 bit_val;
  logic [CNT_W-1:0]     cnt_last;
  logic [CNT_W-1:0]     cnt_half;
  logic [IDX_W-1:0]     nbits_cap;

  logic                 valid_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 perr_q, frame_q, brk_q, ovr_q;

  // Two-flop synchronizer on the asynchronous line, idles high
  always_ff @(posedge i_Clock) begin
    if (rst_i) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= i_Rx_Serial;
      rx_s   <= sync_1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic hist_1, hist_2;

  // Delay line so the FSM sample point has one sample on either side
  always_ff @(posedge i_Clock) begin
    if (rst_i) begin
      hist_1 <= 1'b1;
      hist_2 <= 1'b1;
    end else begin
      hist_1 <= rx_s;
      hist_2 <= hist_1;
    end
  end

  assign line    = hist_1;
  assign bit_val = (hist_2 & hist_1) | (hist_2 & rx_s) | (hist_1 & rx_s);
`else
  assign line    = rx_s;
  assign bit_val = rx_s;
`endif

  assign cnt_last  = cpb_q - CNT_W'(1);
  assign cnt_half  = cnt_last >> 1;
  assign nbits_cap = (i_Num_Bits < IDX_W'(5) || i_Num_Bits > IDX_W'(DATA_BITS))
                     ? IDX_W'(DATA_BITS) : i_Num_Bits;

  // FSM and frame datapath registers
  always_ff @(posedge i_Clock) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      cpb_q      <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_q      <= 1'b0;
      par_bit_q  <= 1'b0;
      ferr_q     <= 1'b0;
      stop_low_q <= 1'b0;
      stop2_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_nx;
      cnt_q      <= cnt_nx;
      idx_q      <= idx_nx;
      shreg_q    <= shreg_nx;
      cpb_q      <= cpb_nx;
      nbits_q    <= nbits_nx;
      par_en_q   <= par_en_nx;
      par_odd_q  <= par_odd_nx;
      two_q      <= two_nx;
      par_bit_q  <= par_bit_nx;
      ferr_q     <= ferr_nx;
      stop_low_q <= stop_low_nx;
      stop2_q    <= stop2_nx;
      done_q     <= done_nx;
    end
  end

  // Next-state and frame capture logic
  always_comb begin
    state_nx    = state_q;
    cnt_nx      = cnt_q;
    idx_nx      = idx_q;
    shreg_nx    = shreg_q;
    cpb_nx      = cpb_q;
    nbits_nx    = nbits_q;
    par_en_nx   = par_en_q;
    par_odd_nx  = par_odd_q;
    two_nx      = two_q;
    par_bit_nx  = par_bit_q;
    ferr_nx     = ferr_q;
    stop_low_nx = stop_low_q;
    stop2_nx    = stop2_q;
    done_nx     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!line) begin
          state_nx    = START;
          cnt_nx      = '0;
          idx_nx      = '0;
          shreg_nx    = '0;
          cpb_nx      = CLKS_PER_BIT;
          nbits_nx    = nbits_cap;
          par_en_nx   = (i_Parity_Mode == 2'b01) || (i_Parity_Mode == 2'b10);
          par_odd_nx  = (i_Parity_Mode == 2'b10);
          two_nx      = i_Two_Stop;
          par_bit_nx  = 1'b0;
          ferr_nx     = 1'b0;
          stop_low_nx = 1'b1;
          stop2_nx    = 1'b0;
        end
      end
      START: begin
        if (cnt_q == cnt_half) begin
          cnt_nx   = '0;
          state_nx = bit_val ? IDLE : DATA;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == cnt_last) begin
          cnt_nx = '0;
          for (int i = 0; i < int'(DATA_BITS); i++) begin
            if (IDX_W'(i) == idx_q) shreg_nx[i] = bit_val;
          end
          idx_nx = idx_q + IDX_W'(1);
          if (idx_q == nbits_q - IDX_W'(1)) state_nx = par_en_q ? PARITY : STOP;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt_q == cnt_last) begin
          cnt_nx     = '0;
          par_bit_nx = bit_val;
          state_nx   = STOP;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == cnt_last) begin
          cnt_nx = '0;
          if (!bit_val) ferr_nx = 1'b1;
          else          stop_low_nx = 1'b0;
          if (two_q && !stop2_q) begin
            stop2_nx = 1'b1;
          end else begin
            done_nx  = 1'b1;
            state_nx = bit_val ? IDLE : BRK_WAIT;
          end
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      BRK_WAIT: begin
        if (line) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Holding register, handshake and overrun pulse
  always_ff @(posedge i_Clock) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      frame_q <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q && (!valid_q || rx_if.rx_ready)) begin
        valid_q <= 1'b1;
        data_q  <= shreg_q;
        perr_q  <= par_en_q && ((^shreg_q ^ par_bit_q) != par_odd_q);
        frame_q <= ferr_q;
        brk_q   <= (shreg_q == '0) && (!par_en_q || !par_bit_q) && stop_low_q;
      end else begin
        if (done_q) ovr_q <= 1'b1;
        if (valid_q && rx_if.rx_ready) valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_valid   = valid_q;
  assign rx_if.rx_data    = data_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = frame_q;
  assign rx_if.rx_break   = brk_q;
  assign rx_if.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: table of frames plus hand-written
// break, overrun, glitch and mid-frame reset sequences.
module tb_uart_rx_cfg;

  logic        clk;
  logic        rst;
  logic        serial;
  logic [15:0] cpb;
  logic [3:0]  nbits;
  logic [1:0]  pmode;
  logic        two;

  int n_cmp = 0;
  int n_err = 0;
  int ovr_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  typedef struct {
    int         cpb;
    logic [3:0] cfg_bits;
    int         send_bits;
    logic [1:0] pmode;
    logic       two;
    logic [7:0] data;
    logic       pbit;
    logic       s1;
    logic       s2;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
    logic       e_brk;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];

  uart_rx_cfg_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_cfg #(.DATA_BITS(8), .CNT_W(16)) dut (
    .i_Clock      (clk),
    .rst_i        (rst),
    .i_Rx_Serial  (serial),
    .CLKS_PER_BIT (cpb),
    .i_Num_Bits   (nbits),
    .i_Parity_Mode(pmode),
    .i_Two_Stop   (two),
    .rx_if        (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe, input logic bk);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    e.brk  = bk;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic par_en,
                            input logic pb, input logic two_stop, input logic s1,
                            input logic s2, input int bt);
    serial = 1'b0;
    tick(bt);
    for (int i = 0; i < nb; i++) begin
      serial = d[i];
      tick(bt);
    end
    if (par_en) begin
      serial = pb;
      tick(bt);
    end
    serial = s1;
    tick(bt);
    if (two_stop) begin
      serial = s2;
      tick(bt);
    end
    serial = 1'b1;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      tick(1);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic set_cfg(input int c, input logic [3:0] b, input logic [1:0] p, input logic t);
    cpb   = 16'(c);
    nbits = b;
    pmode = p;
    two   = t;
  endtask

  // Pops the scoreboard whenever a word is handed over
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_if.overrun === 1'b1) ovr_cnt++;
      if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got data %0h expected none", rx_if.rx_data);
        end else begin
          e = sb.pop_front();
          check("word_data",  32'(rx_if.rx_data),    32'(e.data));
          check("word_perr",  32'(rx_if.parity_err), 32'(e.perr));
          check("word_ferr",  32'(rx_if.frame_err),  32'(e.ferr));
          check("word_break", 32'(rx_if.rx_break),   32'(e.brk));
        end
      end
    end
  endtask

  initial begin
    //          cpb cfg snd pm two data  pb  s1  s2  e_data perr ferr brk
    vecs[0]  = '{16, 4'd8,  8, 2'd0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16, 4'd7,  7, 2'd1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{16, 4'd7,  7, 2'd1, 1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16, 4'd8,  8, 2'd0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16, 4'd8,  8, 2'd0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16, 4'd5,  5, 2'd2, 1'b0, 8'h1F, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16, 4'd5,  5, 2'd2, 1'b0, 8'h1F, 1'b1, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{16, 4'd15, 8, 2'd0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16, 4'd6,  6, 2'd3, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{5,  4'd8,  8, 2'd1, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4,  4'd8,  8, 2'd0, 1'b0, 8'h69, 1'b0, 1'b1, 1'b1, 8'h69, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16, 4'd5,  5, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{16, 4'd4,  8, 2'd0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{16, 4'd8,  8, 2'd1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{16, 4'd7,  7, 2'd2, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0};

    rst    = 1'b1;
    serial = 1'b1;
    rx_if.rx_ready = 1'b1;
    set_cfg(16, 4'd8, 2'd0, 1'b0);
    fork
      monitor();
    join_none
    tick(3);
    rst = 1'b0;
    tick(1);

    check("reset_valid",   32'(rx_if.rx_valid),   32'd0);
    check("reset_data",    32'(rx_if.rx_data),    32'd0);
    check("reset_perr",    32'(rx_if.parity_err), 32'd0);
    check("reset_ferr",    32'(rx_if.frame_err),  32'd0);
    check("reset_break",   32'(rx_if.rx_break),   32'd0);
    check("reset_overrun", 32'(rx_if.overrun),    32'd0);
    tick(20);

    for (int v = 0; v < 15; v++) begin
      set_cfg(vecs[v].cpb, vecs[v].cfg_bits, vecs[v].pmode, vecs[v].two);
      push(vecs[v].e_data, vecs[v].e_perr, vecs[v].e_ferr, vecs[v].e_brk);
      send_frame(vecs[v].data, vecs[v].send_bits,
                 (vecs[v].pmode == 2'd1) || (vecs[v].pmode == 2'd2),
                 vecs[v].pbit, vecs[v].two, vecs[v].s1, vecs[v].s2, vecs[v].cpb);
      tick(2 * vecs[v].cpb);
      wait_drain(200);
    end

    // Line held low for 12 bit times yields a single break word
    set_cfg(16, 4'd8, 2'd0, 1'b0);
    push(8'h00, 1'b0, 1'b1, 1'b1);
    serial = 1'b0;
    tick(12 * 16);
    serial = 1'b1;
    tick(3 * 16);
    wait_drain(200);
    push(8'h81, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    tick(32);
    wait_drain(200);

    // Back-to-back frames with consumer stalled: second one overruns
    check("overrun_before", 32'(ovr_cnt), 32'd0);
    rx_if.rx_ready = 1'b0;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    tick(3 * 16);
    check("overrun_count", 32'(ovr_cnt), 32'd1);
    check("held_valid", 32'(rx_if.rx_valid), 32'd1);
    check("held_data",  32'(rx_if.rx_data),  32'h11);
    push(8'h11, 1'b0, 1'b0, 1'b0);
    rx_if.rx_ready = 1'b1;
    wait_drain(20);
    tick(2);
    check("valid_dropped", 32'(rx_if.rx_valid), 32'd0);

    // Short low glitch on idle line is rejected
    serial = 1'b0;
    tick(3);
    serial = 1'b1;
    tick(4 * 16);
    check("glitch_no_word", 32'(rx_if.rx_valid), 32'd0);
    push(8'hE7, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE7, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    tick(32);
    wait_drain(200);

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inverted pulse inside each data bit, sliding across the midpoint
    push(8'hF0, 1'b0, 1'b0, 1'b0);
    serial = 1'b0;
    tick(16);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] pat;
      pat = 8'hF0;
      serial = pat[k];
      tick(4 + k);
      serial = ~pat[k];
      tick(1);
      serial = pat[k];
      tick(11 - k);
    end
    serial = 1'b1;
    tick(3 * 16);
    wait_drain(200);
`endif

    // Reset in the middle of the data bits aborts the frame
    serial = 1'b0;
    tick(16);
    serial = 1'b1;
    tick(16);
    serial = 1'b0;
    tick(16);
    serial = 1'b0;
    tick(8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    serial = 1'b1;
    tick(1);
    check("reset_mid_valid", 32'(rx_if.rx_valid), 32'd0);
    tick(12 * 16);
    check("reset_mid_no_word", 32'(rx_if.rx_valid), 32'd0);
    push(8'h42, 1'b0, 1'b0, 1'b0);
    send_frame(8'h42, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    tick(32);
    wait_drain(200);

    check("overrun_final", 32'(ovr_cnt), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
